// File: rtl/led_btn_axi_slave_if.sv
// led_btn_axi_slave_if: AXI4-Lite AW/W/B/AR/R channel bundle between PS interconnect and LED/button slave
interface led_btn_axi_slave_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0]   s_axi_awaddr;
  logic            s_axi_awvalid;
  logic            s_axi_awready;
  logic [DW-1:0]   s_axi_wdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic            s_axi_wvalid;
  logic            s_axi_wready;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid;
  logic            s_axi_bready;
  logic [AW-1:0]   s_axi_araddr;
  logic            s_axi_arvalid;
  logic            s_axi_arready;
  logic [DW-1:0]   s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rvalid;
  logic            s_axi_rready;
  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/led_btn_axi_slave.sv
// led_btn_axi_slave: AXI4-Lite slave holding r0..r7; reads return controller reg_out via latched axi_araddr.
// Option LED_BTN_INTCLR_AUTOCLR_EN makes r3[1] (interrupt clear) a one-cycle self-clearing pulse.
module led_btn_axi_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int OPT_MEM_ADDR_BITS  = 2
) (
  input  logic                          clk,
  input  logic                          resetN,
  led_btn_axi_slave_if.slave            s_axi,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] r0, r1, r2, r3, r4, r5, r6, r7,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] reg_out
);
  localparam int ADDR_LSB = C_S_AXI_DATA_WIDTH / 32 + 1;
  localparam int NREG     = 2 ** (OPT_MEM_ADDR_BITS + 1);
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DEC, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [NREG];
  logic [OPT_MEM_ADDR_BITS:0]    w_idx;
  logic                          w_hs;
  assign w_idx = s_axi.s_axi_awaddr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
  assign w_hs  = s_axi.s_axi_awready & s_axi.s_axi_awvalid & s_axi.s_axi_wready & s_axi.s_axi_wvalid;
  assign s_axi.s_axi_bresp = 2'b00;
  assign s_axi.s_axi_rresp = 2'b00;
  always_ff @(posedge clk) begin
    if (!resetN) begin
      w_state             <= W_IDLE;
      s_axi.s_axi_awready <= 1'b0;
      s_axi.s_axi_wready  <= 1'b0;
      s_axi.s_axi_bvalid  <= 1'b0;
    end else begin
      s_axi.s_axi_awready <= 1'b0;
      s_axi.s_axi_wready  <= 1'b0;
      if (w_state == W_IDLE) begin
        if (w_hs) begin
          s_axi.s_axi_bvalid <= 1'b1;
          w_state            <= W_RESP;
        end else if (s_axi.s_axi_awvalid && s_axi.s_axi_wvalid && !s_axi.s_axi_awready) begin
          s_axi.s_axi_awready <= 1'b1;
          s_axi.s_axi_wready  <= 1'b1;
        end
      end else if (s_axi.s_axi_bready) begin
        s_axi.s_axi_bvalid <= 1'b0;
        w_state            <= W_IDLE;
      end
    end
  end
  // The write loop follows the auto-clear so a coinciding software write to r3 wins.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
`ifdef LED_BTN_INTCLR_AUTOCLR_EN
      if (regs[3][1]) regs[3][1] <= 1'b0;
`else
`endif
      if (w_hs && w_state == W_IDLE)
        for (int b = 0; b < C_S_AXI_DATA_WIDTH / 8; b++)
          if (s_axi.s_axi_wstrb[b]) regs[w_idx][b*8 +: 8] <= s_axi.s_axi_wdata[b*8 +: 8];
    end
  end
  // R_DEC gives the controller's combinational decode of axi_araddr a full cycle to settle.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state             <= R_IDLE;
      s_axi.s_axi_arready <= 1'b0;
      s_axi.s_axi_rvalid  <= 1'b0;
      s_axi.s_axi_rdata   <= '0;
      axi_araddr          <= '0;
    end else begin
      s_axi.s_axi_arready <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (s_axi.s_axi_arready && s_axi.s_axi_arvalid) begin
            axi_araddr <= s_axi.s_axi_araddr;
            r_state    <= R_DEC;
          end else if (s_axi.s_axi_arvalid) begin
            s_axi.s_axi_arready <= 1'b1;
          end
        end
        R_DEC: begin
          s_axi.s_axi_rdata  <= reg_out;
          s_axi.s_axi_rvalid <= 1'b1;
          r_state            <= R_DATA;
        end
        default: begin
          if (s_axi.s_axi_rready) begin
            s_axi.s_axi_rvalid <= 1'b0;
            r_state            <= R_IDLE;
          end
        end
      endcase
    end
  end
  assign r0 = regs[0];
  assign r1 = regs[1];
  assign r2 = regs[2];
  assign r3 = regs[3];
  assign r4 = regs[4];
  assign r5 = regs[5];
  assign r6 = regs[6];
  assign r7 = regs[7];
endmodule

// File: tb/tb_led_btn_axi_slave.sv
// tb_led_btn_axi_slave: directed vectors with hand-computed expectations for led_btn_axi_slave.
module tb_led_btn_axi_slave;
`ifdef LED_BTN_INTCLR_AUTOCLR_EN
  localparam bit AC = 1'b1;
`else
  localparam bit AC = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        resetN;
  logic [4:0]  axi_araddr;
  logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [31:0] reg_out, rmux, ovr_val, rd_val;
  logic        use_ovr;
  int          nvec = 0;
  int          nerr = 0;
  led_btn_axi_slave_if #(.DW(32), .AW(5)) bus ();
  led_btn_axi_slave dut (
    .clk(clk), .resetN(resetN), .s_axi(bus), .axi_araddr(axi_araddr),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .reg_out(reg_out)
  );
  always #5 clk = ~clk;
  always_comb begin
    rmux = '0;
    case (axi_araddr[4:2])
      3'd0: rmux = r0;
      3'd1: rmux = r1;
      3'd2: rmux = r2;
      3'd3: rmux = r3;
      3'd4: rmux = r4;
      3'd5: rmux = r5;
      3'd6: rmux = r6;
      default: rmux = r7;
    endcase
  end
  assign reg_out = use_ovr ? ovr_val : rmux;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bus.s_axi_awaddr = a; bus.s_axi_wdata = d; bus.s_axi_wstrb = s;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    tick;
    while (!bus.s_axi_awready && n < 20) begin tick; n++; end
    if (n >= 20) chk("wr_timeout", {31'b0, bus.s_axi_awready}, 32'd1);
    tick;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b1;
    tick;
    bus.s_axi_bready = 1'b0;
  endtask
  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    int n = 0;
    bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1;
    tick;
    while (!bus.s_axi_arready && n < 20) begin tick; n++; end
    tick;
    bus.s_axi_arvalid = 1'b0;
    n = 0;
    while (!bus.s_axi_rvalid && n < 20) begin tick; n++; end
    if (n >= 20) chk("rd_timeout", {31'b0, bus.s_axi_rvalid}, 32'd1);
    d = bus.s_axi_rdata;
    bus.s_axi_rready = 1'b1;
    tick;
    bus.s_axi_rready = 1'b0;
  endtask
  initial begin
    use_ovr = 1'b0; ovr_val = '0;
    bus.s_axi_awaddr = '0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
    resetN = 1'b0;
    repeat (2) begin
      bus.s_axi_awaddr = 5'($urandom); bus.s_axi_wdata = $urandom; bus.s_axi_wstrb = 4'($urandom);
      bus.s_axi_awvalid = 1'($urandom_range(0, 1)); bus.s_axi_wvalid = 1'($urandom_range(0, 1));
      bus.s_axi_araddr = 5'($urandom); bus.s_axi_arvalid = 1'($urandom_range(0, 1));
      bus.s_axi_bready = 1'($urandom_range(0, 1)); bus.s_axi_rready = 1'($urandom_range(0, 1));
      tick;
    end
    chk("rst_bvalid", {31'b0, bus.s_axi_bvalid}, 32'd0);
    chk("rst_rvalid", {31'b0, bus.s_axi_rvalid}, 32'd0);
    chk("rst_readies", {29'b0, bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 32'd0);
    chk("rst_regs", r0 | r1 | r2 | r3 | r4 | r5 | r6 | r7, 32'd0);
    chk("rst_araddr", {27'b0, axi_araddr}, 32'd0);
    chk("rst_rdata", bus.s_axi_rdata, 32'd0);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;
    resetN = 1'b1;
    tick;
    bus.s_axi_awaddr = 5'h00; bus.s_axi_wdata = 32'h0000000A; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    chk("w_c0_awready", {31'b0, bus.s_axi_awready}, 32'd0);
    tick;
    chk("w_c1_readies", {30'b0, bus.s_axi_awready, bus.s_axi_wready}, 32'd3);
    chk("w_c1_bvalid", {31'b0, bus.s_axi_bvalid}, 32'd0);
    tick;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    chk("w_c2_bvalid", {31'b0, bus.s_axi_bvalid}, 32'd1);
    chk("w_c2_r0", r0, 32'h0000000A);
    chk("w_bresp", {30'b0, bus.s_axi_bresp}, 32'd0);
    bus.s_axi_awaddr = 5'h04; bus.s_axi_wdata = 32'h00000005;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    repeat (3) begin
      tick;
      chk("bp_awready", {31'b0, bus.s_axi_awready}, 32'd0);
      chk("bp_bvalid", {31'b0, bus.s_axi_bvalid}, 32'd1);
    end
    bus.s_axi_bready = 1'b1;
    tick;
    bus.s_axi_bready = 1'b0;
    chk("bp_bdrop", {31'b0, bus.s_axi_bvalid}, 32'd0);
    chk("bp_r1_held", r1, 32'd0);
    tick;
    chk("bp2_awready", {31'b0, bus.s_axi_awready}, 32'd1);
    tick;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    chk("bp2_r1", r1, 32'h00000005);
    bus.s_axi_bready = 1'b1;
    tick;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = 5'h00; bus.s_axi_arvalid = 1'b1;
    chk("r_c0_arready", {31'b0, bus.s_axi_arready}, 32'd0);
    tick;
    chk("r_c1_arready", {31'b0, bus.s_axi_arready}, 32'd1);
    tick;
    bus.s_axi_arvalid = 1'b0;
    chk("r_c2_araddr", {27'b0, axi_araddr}, 32'd0);
    chk("r_c2_rvalid", {31'b0, bus.s_axi_rvalid}, 32'd0);
    tick;
    chk("r_c3_rvalid", {31'b0, bus.s_axi_rvalid}, 32'd1);
    chk("r_c3_rdata", bus.s_axi_rdata, 32'h0000000A);
    chk("r_rresp", {30'b0, bus.s_axi_rresp}, 32'd0);
    bus.s_axi_rready = 1'b1;
    tick;
    bus.s_axi_rready = 1'b0;
    chk("r_rdrop", {31'b0, bus.s_axi_rvalid}, 32'd0);
    wr(5'h08, 32'h12345678, 4'b0101);
    chk("strb_r2", r2, 32'h00340078);
    bus.s_axi_awaddr = 5'h18; bus.s_axi_wdata = 32'hDEADBEEF; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b0;
    repeat (3) begin
      tick;
      chk("stag_readies", {30'b0, bus.s_axi_awready, bus.s_axi_wready}, 32'd0);
    end
    bus.s_axi_wvalid = 1'b1;
    tick;
    chk("stag_accept", {30'b0, bus.s_axi_awready, bus.s_axi_wready}, 32'd3);
    tick;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b1;
    chk("stag_r6", r6, 32'hDEADBEEF);
    tick;
    bus.s_axi_bready = 1'b0;
    wr(5'h1F, 32'h00000077, 4'hF);
    chk("wrap_r7", r7, 32'h00000077);
    rd(5'h1C, rd_val);
    chk("wrap_rd", rd_val, 32'h00000077);
    chk("wrap_araddr", {27'b0, axi_araddr}, 32'h1C);
    use_ovr = 1'b1; ovr_val = 32'h11111111;
    bus.s_axi_araddr = 5'h04; bus.s_axi_arvalid = 1'b1;
    tick;
    tick;
    bus.s_axi_arvalid = 1'b0;
    tick;
    chk("rbp_rdata0", bus.s_axi_rdata, 32'h11111111);
    chk("rbp_araddr", {27'b0, axi_araddr}, 32'h04);
    for (int i = 0; i < 5; i++) begin
      ovr_val = 32'hA0000000 + i;
      tick;
      chk("rbp_rdata", bus.s_axi_rdata, 32'h11111111);
      chk("rbp_rvalid", {31'b0, bus.s_axi_rvalid}, 32'd1);
    end
    bus.s_axi_rready = 1'b1;
    tick;
    bus.s_axi_rready = 1'b0;
    use_ovr = 1'b0;
    chk("rbp_rdrop", {31'b0, bus.s_axi_rvalid}, 32'd0);
    bus.s_axi_awaddr = 5'h14; bus.s_axi_wdata = 32'hCAFEF00D; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_araddr = 5'h14;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
    tick;
    tick;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_bready = 1'b1;
    tick;
    bus.s_axi_bready = 1'b0;
    chk("conc_rvalid", {31'b0, bus.s_axi_rvalid}, 32'd1);
    chk("conc_rdata", bus.s_axi_rdata, 32'hCAFEF00D);
    chk("conc_r5", r5, 32'hCAFEF00D);
    bus.s_axi_rready = 1'b1;
    tick;
    bus.s_axi_rready = 1'b0;
    bus.s_axi_awaddr = 5'h0C; bus.s_axi_wdata = 32'h00000003; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    tick;
    tick;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b1;
    chk("ac_r3_c2", r3, 32'h00000003);
    tick;
    bus.s_axi_bready = 1'b0;
    chk("ac_r3_c3", r3, AC ? 32'h00000001 : 32'h00000003);
    tick;
    chk("ac_r3_c4", r3, AC ? 32'h00000001 : 32'h00000003);
    rd(5'h0C, rd_val);
    chk("ac_rd", rd_val, AC ? 32'h00000001 : 32'h00000003);
    chk("final_r0", r0, 32'h0000000A);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
